// File: rtl/mem_loader.sv
// Stream loader for the CPU byte memory: writes DEPTH bytes to consecutive
// addresses, verifies a trailing XOR checksum, and releases the CPU on success.
module mem_loader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_run
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] CHK  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    logic [2:0]    state;
    logic [AW:0]   cnt;
    logic [DW-1:0] sum;

    // Status outputs are pure state decodes so no input reaches them combinationally.
    assign in_ready = (state == LOAD) || (state == CHK);
    assign busy     = in_ready;
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_run  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        we    <= 1'b1;
                        waddr <= cnt[AW-1:0];
                        wdata <= in_data;
                        sum   <= sum ^ in_data;
                        cnt   <= cnt + ONE;
                        if (cnt == LAST) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (in_valid) begin
                        state <= (in_data == sum) ? DONE : ERR;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all restart identically on start.
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed scenarios plus randomized loads,
// compared cycle by cycle against a byte-list reference model.
module tb_mem_loader;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       cpu_run;

    mem_loader #(.DEPTH(8), .AW(3), .DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a load is a list of accepted bytes; result 0 none, 1 good, 2 bad.
    bit         m_load;
    int         m_got;
    int         m_res;
    logic [7:0] m_sum;
    logic [7:0] m_mem [DEPTH];
    bit         e_we;
    int         e_addr;
    logic [7:0] e_data;

    logic [7:0] obs_mem [DEPTH];
    int         n_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [7:0] d, input bit r);
        start    = s;
        in_valid = v;
        in_data  = d;
        rst      = r;
        @(negedge clk);
        check("in_ready", in_ready, m_load);
        check("busy", busy, m_load);
        check("done", done, !m_load && m_res == 1);
        check("err", err, !m_load && m_res == 2);
        check("cpu_run", cpu_run, !m_load && m_res == 1);
        check("we", we, e_we);
        check("waddr", waddr, e_addr);
        check("wdata", wdata, e_data);
        if (we === 1'b1) begin
            obs_mem[waddr] = wdata;
            n_we++;
        end
        if (r) begin
            m_load = 0; m_got = 0; m_res = 0; m_sum = '0;
            e_we = 0; e_addr = 0; e_data = '0;
        end else begin
            e_we = 0;
            if (!m_load) begin
                if (s) begin
                    m_load = 1; m_got = 0; m_sum = '0; m_res = 0;
                end
            end else if (v) begin
                if (m_got < DEPTH) begin
                    e_we = 1; e_addr = m_got; e_data = d;
                    m_mem[m_got] = d;
                    m_sum ^= d;
                    m_got++;
                end else begin
                    m_res  = (d == m_sum) ? 1 : 2;
                    m_load = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offers one byte, stalling randomly; optionally pokes start alongside.
    task automatic offer(input logic [7:0] d, input int stall_pct, input bit poke);
        bit v;
        int tries = 0;
        do begin
            v = (stall_pct == 0) || ($urandom_range(99) >= stall_pct) || (tries > 20);
            step(poke && ($urandom_range(1) == 1), v, v ? d : 8'($urandom), 0);
            tries++;
        end while (!v);
    endtask

    task automatic do_load(input logic [7:0] b [DEPTH], input logic [7:0] cs,
                           input int stall_pct, input bit poke, input int exp_res);
        n_we = 0;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) offer(b[i], stall_pct, poke);
        offer(cs, stall_pct, poke);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        check("load_result", m_res, exp_res);
        check("we_count", n_we, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check("mem", obs_mem[i], b[i]);
            check("model_mem", m_mem[i], b[i]);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] b [DEPTH]);
        logic [7:0] x = '0;
        for (int i = 0; i < DEPTH; i++) x ^= b[i];
        return x;
    endfunction

    logic [7:0] walk [DEPTH] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] pat  [DEPTH] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] rnd  [DEPTH];

    initial begin
        rst = 1; start = 0; in_valid = 0; in_data = '0;
        m_load = 0; m_got = 0; m_res = 0; m_sum = '0;
        e_we = 0; e_addr = 0; e_data = '0; n_we = 0;
        for (int i = 0; i < DEPTH; i++) begin obs_mem[i] = '0; m_mem[i] = '0; end
        @(posedge clk);
        #1;
        step(0, 0, 8'h00, 1);
        // IDLE ignores offered bytes without start
        for (int i = 0; i < 3; i++) step(0, 1, 8'h5A, 0);

        do_load(walk, 8'hFF, 0, 0, 1);
        check("walk_done", done, 1);
        check("walk_cpu_run", cpu_run, 1);
        do_load(walk, 8'h00, 0, 0, 2);
        check("walk_err", err, 1);
        check("walk_err_run", cpu_run, 0);
        do_load(walk, 8'hFF, 0, 0, 1);
        check("reload_err", err, 0);

        do_load(pat, xsum(pat), 50, 0, 1);
        check("pat_done", done, 1);

        do_load(walk, xsum(walk), 30, 1, 1);

        // reset after four transfers, then a clean reload from address 0
        n_we = 0;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) offer(8'hC0 + 8'(i), 0, 0);
        step(0, 1, 8'hEE, 1);
        step(0, 1, 8'hEE, 0);
        step(0, 0, 8'h00, 0);
        check("rst_wecnt", n_we, 4);
        do_load(walk, 8'hFF, 0, 0, 1);

        for (int t = 0; t < 25; t++) begin
            bit good;
            for (int i = 0; i < DEPTH; i++) rnd[i] = 8'($urandom);
            good = ($urandom_range(2) != 0);
            do_load(rnd, good ? xsum(rnd) : (xsum(rnd) ^ 8'(1 + $urandom_range(254))),
                    $urandom_range(60), ($urandom_range(1) == 1), good ? 1 : 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
